// File: rtl/idli_pc_ctl_m_if.sv
// idli_pc_ctl_m_if: request/response bundle between the PC word sequencer
// and its clients (execute-stage branch requester, trap requester, PC unit).
// The slave modport is the sequencer's view; the master modport is the
// view of whatever drives requests and consumes the PC-unit controls.
interface idli_pc_ctl_m_if;
   logic        i_pcc_stall;
   logic        i_pcc_br_vld;
   logic [15:0] i_pcc_br_addr;
   logic        o_pcc_br_rdy;
   logic        i_pcc_trap_vld;
   logic        o_pcc_trap_rdy;
   logic [1:0]  o_pcc_ctr;
   logic        o_pcc_inc;
   logic        o_pcc_redirect;
   logic [3:0]  o_pcc_data;
   logic        o_pcc_busy;

   modport slave (
      input  i_pcc_stall,
      input  i_pcc_br_vld,
      input  i_pcc_br_addr,
      output o_pcc_br_rdy,
      input  i_pcc_trap_vld,
      output o_pcc_trap_rdy,
      output o_pcc_ctr,
      output o_pcc_inc,
      output o_pcc_redirect,
      output o_pcc_data,
      output o_pcc_busy
   );

   modport master (
      output i_pcc_stall,
      output i_pcc_br_vld,
      output i_pcc_br_addr,
      input  o_pcc_br_rdy,
      output i_pcc_trap_vld,
      input  o_pcc_trap_rdy,
      input  o_pcc_ctr,
      input  o_pcc_inc,
      input  o_pcc_redirect,
      input  o_pcc_data,
      input  o_pcc_busy
   );
endinterface

// File: rtl/idli_pc_ctl_m.sv
// idli_pc_ctl_m: word-level sequencer for the bit-serial PC slice unit
// (16-bit PC, 4-bit slices, 4 cycles per word). Drives the slice counter,
// picks the mode of each word (increment / hold / redirect) at the last
// slice of the previous word, arbitrates redirect sources and streams the
// chosen target out LSB slice first.
// Optional feature macro: IDLI_PCC_TRAP_EN enables the trap requester,
// which then has priority over the branch requester.
module idli_pc_ctl_m #(
   parameter logic [15:0] TRAP_VECTOR = 16'h0004
) (
   input logic            i_pcc_gck,
   input logic            i_pcc_rst,
   idli_pc_ctl_m_if.slave pcc
);

   typedef logic [1:0] ctr_t;
   typedef logic [3:0] slice_t;
   typedef enum logic [1:0] {RUN_INC, RUN_HOLD, REDIR} mode_t;

   ctr_t        ctr_q;
   mode_t       mode_q;
   mode_t       mode_d;
   logic [15:0] tgt_q;
   logic [15:0] tgt_d;
   logic        inc_q;
   logic        redir_q;
   logic        word_end;
   logic        trap_take;
   logic        br_take;

   // Decisions are only taken on the last slice of a word, and never while
   // reset is held so a reset cycle acknowledges nothing.
   assign word_end = (ctr_q == 2'd3) && !i_pcc_rst;

`ifdef IDLI_PCC_TRAP_EN
   assign trap_take = word_end && pcc.i_pcc_trap_vld;
`else
   logic unused_trap_vld;
   assign unused_trap_vld = pcc.i_pcc_trap_vld;
   assign trap_take       = 1'b0;
`endif

   // A pending branch loses to a same-cycle trap and simply stays pending.
   assign br_take = word_end && pcc.i_pcc_br_vld && !trap_take;

   // Next word mode and target: trap, then branch, then stall, else run.
   always_comb begin
      mode_d = RUN_INC;
      tgt_d  = '0;
      if (trap_take) begin
         mode_d = REDIR;
         tgt_d  = TRAP_VECTOR;
      end else if (br_take) begin
         mode_d = REDIR;
         tgt_d  = pcc.i_pcc_br_addr;
      end else if (pcc.i_pcc_stall) begin
         mode_d = RUN_HOLD;
      end
   end

   // Slice counter, per-word mode register and target shift register.
   always_ff @(posedge i_pcc_gck) begin
      if (i_pcc_rst) begin
         ctr_q   <= '0;
         mode_q  <= RUN_HOLD;
         tgt_q   <= '0;
         inc_q   <= 1'b0;
         redir_q <= 1'b0;
      end else begin
         ctr_q <= ctr_q + 2'd1;
         if (word_end) begin
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            inc_q   <= (mode_d == RUN_INC);
            redir_q <= (mode_d == REDIR);
         end else if (mode_q == REDIR) begin
            tgt_q <= {4'h0, tgt_q[15:4]};
         end
      end
   end

   assign pcc.o_pcc_ctr      = ctr_q;
   assign pcc.o_pcc_inc      = inc_q;
   assign pcc.o_pcc_redirect = redir_q;
   assign pcc.o_pcc_busy     = redir_q;
   assign pcc.o_pcc_data     = redir_q ? slice_t'(tgt_q[3:0]) : slice_t'(4'h0);
   assign pcc.o_pcc_br_rdy   = br_take;
   assign pcc.o_pcc_trap_rdy = trap_take;

   // Requesters must hold valid (and the branch target) until accepted.
   br_hold_a : assert property (@(posedge i_pcc_gck) disable iff (i_pcc_rst)
      (pcc.i_pcc_br_vld && !pcc.o_pcc_br_rdy) |=> pcc.i_pcc_br_vld);
   br_addr_a : assert property (@(posedge i_pcc_gck) disable iff (i_pcc_rst)
      (pcc.i_pcc_br_vld && !pcc.o_pcc_br_rdy) |=> $stable(pcc.i_pcc_br_addr));
`ifdef IDLI_PCC_TRAP_EN
   trap_hold_a : assert property (@(posedge i_pcc_gck) disable iff (i_pcc_rst)
      (pcc.i_pcc_trap_vld && !pcc.o_pcc_trap_rdy) |=> pcc.i_pcc_trap_vld);
`endif
   rdy_slot_a : assert property (@(posedge i_pcc_gck)
      (pcc.o_pcc_br_rdy || pcc.o_pcc_trap_rdy) |->
      (ctr_q == 2'd3) && !(pcc.o_pcc_br_rdy && pcc.o_pcc_trap_rdy));

endmodule

// File: tb/tb_idli_pc_ctl_m.sv
// tb_idli_pc_ctl_m: scenario bench for the PC word sequencer. A small PC
// unit model assembles the PC from the sequencer's outputs; each scenario
// queues the words it expects and compares them as they are produced.
module tb_idli_pc_ctl_m;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   idli_pc_ctl_m_if pcc();

   idli_pc_ctl_m #(.TRAP_VECTOR(16'h0004)) dut (
      .i_pcc_gck (clk),
      .i_pcc_rst (rst),
      .pcc       (pcc)
   );

   typedef struct packed {
      logic [7:0]  ctrs;
      logic [3:0]  inc;
      logic [3:0]  redir;
      logic [3:0]  busy;
      logic [15:0] data;
      logic [15:0] pc;
   } word_t;
   typedef enum {W_INC, W_HOLD, W_REDIR} wkind_t;

   word_t       sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [15:0] exp_pc;
   logic [15:0] pc_obs;

   // PC unit model: slice writes during redirect, +1 at the end of an inc word.
   always @(posedge clk) begin
      if (rst) pc_obs <= '0;
      else if (pcc.o_pcc_redirect) pc_obs[{pcc.o_pcc_ctr, 2'b00} +: 4] <= pcc.o_pcc_data;
      else if (pcc.o_pcc_inc && pcc.o_pcc_ctr == 2'd3) pc_obs <= pc_obs + 16'd1;
   end

   task automatic push_word(input wkind_t k, input logic [15:0] tgt);
      word_t w;
      w = '0;
      w.ctrs = 8'hE4;
      case (k)
         W_INC:   begin w.inc = 4'hF; exp_pc = exp_pc + 16'd1; end
         W_HOLD:  ;
         default: begin w.redir = 4'hF; w.busy = 4'hF; w.data = tgt; exp_pc = tgt; end
      endcase
      w.pc = exp_pc;
      sb_q.push_back(w);
   endtask

   task automatic wait_ctr(input logic [1:0] v);
      int n = 0;
      @(negedge clk);
      while (pcc.o_pcc_ctr !== v && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (pcc.o_pcc_ctr !== v) begin
         n_cmp++; n_mis++;
         $display("FAIL wait_ctr: ctr=%0d never reached %0d", pcc.o_pcc_ctr, v);
      end
   endtask

   task automatic capture_word(output word_t o);
      o = '0;
      wait_ctr(2'd0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         o.ctrs[2*i +: 2] = pcc.o_pcc_ctr;
         o.inc[i]         = pcc.o_pcc_inc;
         o.redir[i]       = pcc.o_pcc_redirect;
         o.busy[i]        = pcc.o_pcc_busy;
         o.data[4*i +: 4] = pcc.o_pcc_data;
      end
      @(posedge clk);
      #1;
      o.pc = pc_obs;
   endtask

   task automatic test_reset();
      word_t obs, exp_w;
      rst = 1'b1;
      pcc.i_pcc_stall = 1'b0; pcc.i_pcc_br_vld = 1'b0; pcc.i_pcc_br_addr = '0;
      pcc.i_pcc_trap_vld = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({pcc.o_pcc_ctr, pcc.o_pcc_inc, pcc.o_pcc_redirect, pcc.o_pcc_data, pcc.o_pcc_busy,
           pcc.o_pcc_br_rdy, pcc.o_pcc_trap_rdy} !== 11'h0) begin
         n_mis++;
         $display("FAIL reset_state: ctr=%0d inc=%b redir=%b data=%h busy=%b rdy=%b%b, expected all 0",
                  pcc.o_pcc_ctr, pcc.o_pcc_inc, pcc.o_pcc_redirect, pcc.o_pcc_data,
                  pcc.o_pcc_busy, pcc.o_pcc_br_rdy, pcc.o_pcc_trap_rdy);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      exp_pc = '0;
      push_word(W_HOLD, 16'h0);
      repeat (3) push_word(W_INC, 16'h0);
      for (int i = 0; i < 4; i++) begin
         capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
         if (obs !== exp_w) begin
            n_mis++;
            $display("FAIL reset word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                     i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                     exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
         end
      end
   endtask

   task automatic test_branch();
      word_t obs, exp_w;
      push_word(W_INC, 16'h0);
      push_word(W_REDIR, 16'hBEEF);
      push_word(W_INC, 16'h0);
      fork
         begin
            wait_ctr(2'd1);
            pcc.i_pcc_br_vld = 1'b1; pcc.i_pcc_br_addr = 16'hBEEF;
            #1 n_cmp++;
            if (pcc.o_pcc_br_rdy !== 1'b0) begin
               n_mis++; $display("FAIL branch early_rdy: br_rdy=%b at ctr1, expected 0", pcc.o_pcc_br_rdy);
            end
            wait_ctr(2'd3); n_cmp++;
            if (pcc.o_pcc_br_rdy !== 1'b1) begin
               n_mis++; $display("FAIL branch accept: br_rdy=%b at ctr3, expected 1", pcc.o_pcc_br_rdy);
            end
            @(posedge clk);
            #1 pcc.i_pcc_br_vld = 1'b0;
         end
         begin
            for (int i = 0; i < 3; i++) begin
               capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
               if (obs !== exp_w) begin
                  n_mis++;
                  $display("FAIL branch word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                           i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                           exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
               end
            end
         end
      join
   endtask

   task automatic test_trap();
      word_t obs, exp_w;
      int    n_words;
      push_word(W_INC, 16'h0);
`ifdef IDLI_PCC_TRAP_EN
      push_word(W_REDIR, 16'h0004);
      n_words = 4;
`else
      n_words = 3;
`endif
      push_word(W_REDIR, 16'h1234);
      push_word(W_INC, 16'h0);
      fork
         begin
            wait_ctr(2'd0);
            pcc.i_pcc_trap_vld = 1'b1; pcc.i_pcc_br_vld = 1'b1; pcc.i_pcc_br_addr = 16'h1234;
`ifdef IDLI_PCC_TRAP_EN
            wait_ctr(2'd3); n_cmp++;
            if ({pcc.o_pcc_trap_rdy, pcc.o_pcc_br_rdy} !== 2'b10) begin
               n_mis++; $display("FAIL trap priority: trap_rdy,br_rdy=%b, expected 10",
                                 {pcc.o_pcc_trap_rdy, pcc.o_pcc_br_rdy});
            end
            @(posedge clk);
            #1 pcc.i_pcc_trap_vld = 1'b0;
`endif
            wait_ctr(2'd3); n_cmp++;
            if ({pcc.o_pcc_trap_rdy, pcc.o_pcc_br_rdy} !== 2'b01) begin
               n_mis++; $display("FAIL trap branch_accept: trap_rdy,br_rdy=%b, expected 01",
                                 {pcc.o_pcc_trap_rdy, pcc.o_pcc_br_rdy});
            end
            @(posedge clk);
            #1 pcc.i_pcc_br_vld = 1'b0; pcc.i_pcc_trap_vld = 1'b0;
         end
         begin
            for (int i = 0; i < n_words; i++) begin
               capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
               if (obs !== exp_w) begin
                  n_mis++;
                  $display("FAIL trap word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                           i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                           exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
               end
            end
         end
      join
   endtask

   task automatic test_stall();
      word_t obs, exp_w;
      push_word(W_INC, 16'h0);
      push_word(W_REDIR, 16'h0010);
      repeat (3) push_word(W_HOLD, 16'h0);
      push_word(W_INC, 16'h0);
      fork
         begin
            wait_ctr(2'd0);
            pcc.i_pcc_br_vld = 1'b1; pcc.i_pcc_br_addr = 16'h0010;
            wait_ctr(2'd3); n_cmp++;
            if (pcc.o_pcc_br_rdy !== 1'b1) begin
               n_mis++; $display("FAIL stall setup_accept: br_rdy=%b, expected 1", pcc.o_pcc_br_rdy);
            end
            @(posedge clk);
            #1 pcc.i_pcc_br_vld = 1'b0; pcc.i_pcc_stall = 1'b1;
            repeat (3) wait_ctr(2'd3);
            @(posedge clk);
            #1 pcc.i_pcc_stall = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) begin
               capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
               if (obs !== exp_w) begin
                  n_mis++;
                  $display("FAIL stall word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                           i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                           exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
               end
            end
         end
      join
   endtask

   task automatic test_back_to_back();
      word_t obs, exp_w;
      push_word(W_INC, 16'h0);
      push_word(W_REDIR, 16'h00A0);
      push_word(W_REDIR, 16'h0F00);
      push_word(W_INC, 16'h0);
      fork
         begin
            wait_ctr(2'd0);
            pcc.i_pcc_br_vld = 1'b1; pcc.i_pcc_br_addr = 16'h00A0; pcc.i_pcc_stall = 1'b1;
            wait_ctr(2'd3); n_cmp++;
            if (pcc.o_pcc_br_rdy !== 1'b1) begin
               n_mis++; $display("FAIL b2b first_accept: br_rdy=%b, expected 1", pcc.o_pcc_br_rdy);
            end
            @(posedge clk);
            #1 pcc.i_pcc_br_addr = 16'h0F00;
            wait_ctr(2'd3); n_cmp++;
            if (pcc.o_pcc_br_rdy !== 1'b1) begin
               n_mis++; $display("FAIL b2b second_accept: br_rdy=%b, expected 1", pcc.o_pcc_br_rdy);
            end
            @(posedge clk);
            #1 pcc.i_pcc_br_vld = 1'b0; pcc.i_pcc_stall = 1'b0;
         end
         begin
            for (int i = 0; i < 4; i++) begin
               capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
               if (obs !== exp_w) begin
                  n_mis++;
                  $display("FAIL b2b word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                           i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                           exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
               end
            end
         end
      join
   endtask

   task automatic test_reset_mid();
      word_t obs, exp_w;
      wait_ctr(2'd0);
      pcc.i_pcc_br_vld = 1'b1; pcc.i_pcc_br_addr = 16'h5555;
      wait_ctr(2'd3); n_cmp++;
      if (pcc.o_pcc_br_rdy !== 1'b1) begin
         n_mis++; $display("FAIL rstmid accept: br_rdy=%b, expected 1", pcc.o_pcc_br_rdy);
      end
      @(posedge clk);
      #1 pcc.i_pcc_br_vld = 1'b0;
      wait_ctr(2'd1); n_cmp++;
      if ({pcc.o_pcc_redirect, pcc.o_pcc_busy, pcc.o_pcc_data} !== 6'b11_0101) begin
         n_mis++; $display("FAIL rstmid in_word: redir=%b busy=%b data=%h, expected 1 1 5",
                           pcc.o_pcc_redirect, pcc.o_pcc_busy, pcc.o_pcc_data);
      end
      wait_ctr(2'd2);
      rst = 1'b1;
      @(posedge clk);
      #1 n_cmp++;
      if ({pcc.o_pcc_ctr, pcc.o_pcc_inc, pcc.o_pcc_redirect, pcc.o_pcc_data, pcc.o_pcc_busy,
           pcc.o_pcc_br_rdy, pcc.o_pcc_trap_rdy} !== 11'h0) begin
         n_mis++;
         $display("FAIL rstmid state: ctr=%0d inc=%b redir=%b data=%h busy=%b rdy=%b%b, expected all 0",
                  pcc.o_pcc_ctr, pcc.o_pcc_inc, pcc.o_pcc_redirect, pcc.o_pcc_data,
                  pcc.o_pcc_busy, pcc.o_pcc_br_rdy, pcc.o_pcc_trap_rdy);
      end
      rst = 1'b0;
      exp_pc = '0;
      push_word(W_HOLD, 16'h0);
      push_word(W_INC, 16'h0);
      for (int i = 0; i < 2; i++) begin
         capture_word(obs); exp_w = sb_q.pop_front(); n_cmp++;
         if (obs !== exp_w) begin
            n_mis++;
            $display("FAIL rstmid word%0d: got ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h, expected ctr=%h inc=%h redir=%h busy=%h data=%h pc=%h",
                     i, obs.ctrs, obs.inc, obs.redir, obs.busy, obs.data, obs.pc,
                     exp_w.ctrs, exp_w.inc, exp_w.redir, exp_w.busy, exp_w.data, exp_w.pc);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_branch();
      test_trap();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/idli_pc_ctl_m.md
Name: idli_pc_ctl_m

Overview:
- Word-level sequencer for the bit-serial PC slice unit (16-bit PC, 4-bit slices, 4 cycles per word).
- Generates the slice counter plus the per-word increment/redirect controls for the PC unit.
- Arbitrates redirect targets between the execute-stage branch requester and the trap requester.
- Serialises the chosen 16-bit target onto the PC unit's slice data input, LSB slice first.

Parameters:
- TRAP_VECTOR, 16'h0004, PC value loaded on an accepted trap (used only with IDLI_PCC_TRAP_EN).

Ports:
- i_pcc_gck  in  1  clock.
- i_pcc_rst  in  1  synchronous reset, active-high.
- i_pcc_stall  in  1  hold PC for the next word (no increment); sampled at ctr==3.
- i_pcc_br_vld  in  1  branch redirect request, valid/ready.
- i_pcc_br_addr  in  16  branch target; stable while i_pcc_br_vld is high.
- o_pcc_br_rdy  out  1  branch request accepted this cycle.
- i_pcc_trap_vld  in  1  trap redirect request, valid/ready.
- o_pcc_trap_rdy  out  1  trap request accepted this cycle.
- o_pcc_ctr  out  2  slice counter (ctr_t) to the PC unit.
- o_pcc_inc  out  1  PC increment enable for the current word.
- o_pcc_redirect  out  1  PC redirect for the current word.
- o_pcc_data  out  4  redirect target slice (slice_t).
- o_pcc_busy  out  1  a redirect word is in progress.

Behaviour:
- Reset values: ctr=0, mode=RUN_HOLD, target register=0. All outputs 0.
- Reset is honoured mid-word. It discards any captured target and acks nothing.
- ctr increments every cycle: 0,1,2,3,0,... with 2-bit wrap. It never stalls.
- Word modes, registered at the end of the ctr==3 cycle and held constant for the following 4 cycles:
  - RUN_INC: o_pcc_inc=1, o_pcc_redirect=0.
  - RUN_HOLD: o_pcc_inc=0, o_pcc_redirect=0.
  - REDIR: o_pcc_inc=0, o_pcc_redirect=1, o_pcc_busy=1.
- The first word after reset is RUN_HOLD, so the PC shows 0 for one full word.
- Next-mode priority, evaluated in the ctr==3 cycle:
  1. trap_vld (with TRAP_EN) -> REDIR, target=TRAP_VECTOR, o_pcc_trap_rdy=1 for that cycle.
  2. br_vld -> REDIR, target=br_addr, o_pcc_br_rdy=1 for that cycle.
  3. stall -> RUN_HOLD.
  4. otherwise -> RUN_INC.
- rdy signals are only ever high in a ctr==3 cycle, and at most one is high per cycle.
- Simultaneous trap and branch: the trap wins. br_vld stays pending and is re-arbitrated at the next ctr==3.
- A request arriving at ctr 0..2 is held by the requester and considered at ctr==3. Maximum accept latency is 4 cycles.
- Dropping vld before rdy is a protocol violation. An assertion must check it; RTL behaviour in that case is undefined.
- Target serialisation: 16-bit shift register loaded at the end of ctr==3.
  - During REDIR, o_pcc_data = tgt_q[3:0]; tgt_q shifts right 4 each cycle.
  - Slice order per word is target[3:0], [7:4], [11:8], [15:12] at ctr 0..3.
  - o_pcc_data=0 outside REDIR.
- Back-to-back redirects (REDIR -> REDIR) are allowed. The new target is loaded at the ctr==3 cycle of the current redirect word, after its final slice has been driven.
- stall with no request holds the PC value unchanged word after word. Stall never blocks a redirect.

Optional Feature:
- IDLI_PCC_TRAP_EN defined: trap requester active as above, with priority over branch.
- Undefined: i_pcc_trap_vld ignored; o_pcc_trap_rdy tied 0; TRAP_VECTOR unused. Branch is the only redirect source.

Test Plan:
- Reset release, no requests, stall=0 -> word0 RUN_HOLD (PC=0x0000); words 1..3 inc=1; PC reaches 0x0003 at the start of word 4.
- br_vld at ctr==1 with addr=0xBEEF -> br_rdy at the next ctr==3; next word redirect=1, data 0xF,0xE,0xE,0xB; PC=0xBEEF after that word.
- trap_vld and br_vld (addr=0x1234) both high at ctr==3, TRAP_EN defined -> trap_rdy=1, br_rdy=0; PC=0x0004; next word br accepted; PC=0x1234.
- stall held for 3 words at PC=0x0010 -> inc=0 for those 3 words; PC remains 0x0010; inc resumes the word after stall drops.
- Two branches back-to-back (0x00A0 then 0x0F00) -> consecutive REDIR words, busy=1 for 8 cycles, PC ends 0x0F00.
- rst asserted at ctr==2 of a REDIR word to 0x5555 -> next cycle ctr=0, redirect=0, data=0, busy=0; no rdy issued.
